dual_port_memory: RTL and testbench
===================================

DUAL_PORT_MEMORY -- requirements
Module: dual_port_memory

Interface
REQ-001 Parameter DATA_W, default 16, word width in bits.
REQ-002 Parameter ADDR_W, default 9, address width in bits.
REQ-003 Parameter DEPTH, default 257, number of words; legal range 2 to 2**ADDR_W.
REQ-004 Parameter CLEAR_VAL, default 0, value written to every word during the clear sequence.
REQ-005 Port clock, input, 1, clock; all state updates on its rising edge.
REQ-006 Port reset, input, 1, synchronous, active-high reset.
REQ-007 Port ready, output, 1, high when the clear sequence is done and requests are accepted.
REQ-008 Port a_req, input, 1, fetch-port read request.
REQ-009 Port a_addr, input, ADDR_W, fetch-port address.
REQ-010 Port a_data, output, DATA_W, fetch-port read data.
REQ-011 Port a_valid, output, 1, one-cycle pulse qualifying a_data.
REQ-012 Port b_req, input, 1, data-port request.
REQ-013 Port b_we, input, 1, data-port write enable; 1 = write, 0 = read.
REQ-014 Port b_addr, input, ADDR_W, data-port address.
REQ-015 Port b_wdata, input, DATA_W, data-port write data.
REQ-016 Port b_rdata, output, DATA_W, data-port read data.
REQ-017 Port b_valid, output, 1, one-cycle pulse qualifying b_rdata.
REQ-018 Port err, output, 1, one-cycle pulse on any accepted request with address >= DEPTH.

Function
REQ-019 The state machine SHALL have two states: CLEAR and RUN.
REQ-020 In CLEAR, a pointer SHALL write CLEAR_VAL to one word per cycle, from 0 to DEPTH-1, then enter RUN on the next edge; CLEAR lasts exactly DEPTH cycles.
REQ-021 ready SHALL be 0 in CLEAR and 1 in RUN.
REQ-022 In CLEAR, requests SHALL be ignored: no valid pulse, no err, no array write.
REQ-023 A request SHALL be accepted on an edge where ready=1 and req=1.
REQ-024 An accepted read SHALL present data on a_data or b_rdata with the valid pulse exactly one cycle after acceptance.
REQ-025 The data outputs SHALL hold their last value until the next valid read.
REQ-026 An accepted b write SHALL update the array at that edge and SHALL NOT pulse b_valid.
REQ-027 A b write and an a read to the same address on the same edge SHALL return the old word on a_data (read-before-write).
REQ-028 A b read followed by an a read of the same address SHALL return identical data.
REQ-029 Out-of-range address (>= DEPTH) handling:
- writes SHALL NOT modify the array;
- reads SHALL return 0 with valid pulsed;
- err SHALL pulse one cycle after acceptance.
REQ-030 If both ports are out of range on the same edge, err SHALL pulse once.
REQ-031 Addresses SHALL NOT wrap; an out-of-range index never aliases a legal word.

Reset
REQ-032 reset=1 at an edge SHALL force CLEAR with pointer 0, from any state, including mid-clear.
REQ-033 Under reset: ready=0, a_valid=0, b_valid=0, err=0, a_data=0, b_rdata=0.
REQ-034 A read accepted the cycle before reset SHALL NOT produce a valid pulse.
REQ-035 After reset deasserts, ready SHALL rise exactly DEPTH cycles later, with all words equal to CLEAR_VAL.

Verification
REQ-036 Reset, then read all addresses: ready rises after 257 cycles; every read returns 0.
REQ-037 b write 0x0008 to addr 0, then a read addr 0: a_data=0x0008, a_valid pulsed one cycle after acceptance.
REQ-038 Same edge, b write 0x1234 to addr 5 and a read addr 5 (holding 0x00AA): a_data=0x00AA; next a read gives 0x1234.
REQ-039 b write to addr 300: err pulses; array unchanged. a read to addr 300: a_data=0, a_valid=1, err=1.
REQ-040 Assert reset at clear cycle 100, release: ready rises 257 cycles after release; any word written before reset reads 0.
REQ-041 Requests held high during CLEAR: no valid pulses, no err, and the first acceptance occurs on the first edge with ready=1.

Source files
------------

// File: rtl/dual_port_memory.sv
// Two-port word memory: port a reads, port b reads or writes.
// After reset every word is overwritten with CLEAR_VAL before any request is accepted.
module dual_port_memory #(
    parameter int unsigned       DATA_W    = 16,
    parameter int unsigned       ADDR_W    = 9,
    parameter int unsigned       DEPTH     = 257,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic              clock,
    input  logic              reset,
    output logic              ready,
    input  logic              a_req,
    input  logic [ADDR_W-1:0] a_addr,
    output logic [DATA_W-1:0] a_data,
    output logic              a_valid,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_valid,
    output logic              err
);

    localparam logic [ADDR_W:0]   DepthExt = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LastPtr  = ADDR_W'(DEPTH - 1);

    typedef enum logic [0:0] {StClear, StRun} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              run, clear_we;
    logic              a_acc, b_acc, a_in, b_in;
    logic              a_valid_q, b_valid_q, err_q;
    logic [DATA_W-1:0] a_data_q, b_rdata_q;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StClear;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StClear: if (ptr_q == LastPtr) state_d = StRun;
            StRun:   state_d = StRun;
            default: state_d = StClear;
        endcase
    end

    // Output decode
    always_comb begin
        run      = (state_q == StRun);
        clear_we = (state_q == StClear);
    end

    // Outputs are masked while reset is high so a read accepted just before reset never shows.
    assign ready = run & ~reset;

    assign a_acc = ready & a_req;
    assign b_acc = ready & b_req;
    assign a_in  = {1'b0, a_addr} < DepthExt;
    assign b_in  = {1'b0, b_addr} < DepthExt;

    always_ff @(posedge clock) begin
        if (reset || !clear_we) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (clear_we && !reset) begin
            mem[ptr_q] <= CLEAR_VAL;
        end else if (b_acc && b_we && b_in) begin
            mem[b_addr] <= b_wdata;
        end
    end

    // Reads sample the array before this edge's write lands, giving read-before-write.
    always_ff @(posedge clock) begin
        if (reset) begin
            a_valid_q <= 1'b0;
            b_valid_q <= 1'b0;
            err_q     <= 1'b0;
            a_data_q  <= '0;
            b_rdata_q <= '0;
        end else begin
            a_valid_q <= a_acc;
            b_valid_q <= b_acc & ~b_we;
            err_q     <= (a_acc & ~a_in) | (b_acc & ~b_in);
            if (a_acc) begin
                a_data_q <= a_in ? mem[a_addr] : '0;
            end
            if (b_acc && !b_we) begin
                b_rdata_q <= b_in ? mem[b_addr] : '0;
            end
        end
    end

    assign a_valid = a_valid_q & ~reset;
    assign b_valid = b_valid_q & ~reset;
    assign err     = err_q & ~reset;
    assign a_data  = reset ? '0 : a_data_q;
    assign b_rdata = reset ? '0 : b_rdata_q;

endmodule

// File: tb/tb_dual_port_memory.sv
// Randomised and directed bench for dual_port_memory against an array-based reference model.
module tb_dual_port_memory;

    localparam int DW    = 16;
    localparam int AW    = 9;
    localparam int DEPTH = 257;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          a_req = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [DW-1:0] b_wdata = '0;
    logic [DW-1:0] a_data, b_rdata;
    logic          ready, a_valid, b_valid, err;

    dual_port_memory #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .DEPTH    (DEPTH),
        .CLEAR_VAL(16'h0000)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .ready  (ready),
        .a_req  (a_req),
        .a_addr (a_addr),
        .a_data (a_data),
        .a_valid(a_valid),
        .b_req  (b_req),
        .b_we   (b_we),
        .b_addr (b_addr),
        .b_wdata(b_wdata),
        .b_rdata(b_rdata),
        .b_valid(b_valid),
        .err    (err)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: word array plus remaining clear cycles.
    logic [DW-1:0] mdl [DEPTH];
    int            clr_left = DEPTH;
    logic          e_av = 0, e_bv = 0, e_err = 0, e_rdy = 0;
    logic [DW-1:0] e_ad = '0, e_bd = '0;

    task automatic apply(input logic rst, input logic ar, input int aa, input logic br,
                         input logic bwe, input int ba, input logic [DW-1:0] bwd);
        reset   = rst;
        a_req   = ar;
        a_addr  = AW'(aa);
        b_req   = br;
        b_we    = bwe;
        b_addr  = AW'(ba);
        b_wdata = bwd;
        if (rst) begin
            clr_left = DEPTH;
            for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
            e_av = 0; e_bv = 0; e_err = 0; e_rdy = 0; e_ad = '0; e_bd = '0;
        end else if (clr_left > 0) begin
            clr_left--;
            e_av = 0; e_bv = 0; e_err = 0;
            e_rdy = (clr_left == 0);
        end else begin
            e_av  = ar;
            e_bv  = br && !bwe;
            e_err = (ar && aa >= DEPTH) || (br && ba >= DEPTH);
            if (ar) e_ad = (aa < DEPTH) ? mdl[aa] : '0;
            if (br && !bwe) e_bd = (ba < DEPTH) ? mdl[ba] : '0;
            if (br && bwe && ba < DEPTH) mdl[ba] = bwd;
            e_rdy = 1;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            apply(1, 1, 3, 1, 0, 4, '0);
            vectors++;
            if ({ready, a_valid, b_valid, err} !== 4'b0000 || a_data !== '0 || b_rdata !== '0) begin
                miscompares++;
                $display("FAIL reset_outputs: ready=%b av=%b bv=%b err=%b ad=%h bd=%h, required all zero",
                         ready, a_valid, b_valid, err, a_data, b_rdata);
            end
        end
    endtask

    // Requests held high straight out of reset: nothing may be accepted until ready.
    task automatic test_clear_ignored();
        int first_ready = -1;
        for (int cyc = 1; cyc <= DEPTH + 6; cyc++) begin
            apply(0, 1, $urandom_range(0, DEPTH + 20), 1, 1'($urandom), $urandom_range(0, DEPTH + 20),
                  DW'($urandom));
            if (ready && first_ready < 0) first_ready = cyc;
            vectors++;
            if (ready !== e_rdy || a_valid !== e_av || b_valid !== e_bv || err !== e_err) begin
                miscompares++;
                $display("FAIL clear_ctl cyc %0d: rdy/av/bv/err=%b%b%b%b, required %b%b%b%b", cyc,
                         ready, a_valid, b_valid, err, e_rdy, e_av, e_bv, e_err);
            end
            vectors++;
            if (a_data !== e_ad || b_rdata !== e_bd) begin
                miscompares++;
                $display("FAIL clear_data cyc %0d: ad=%h bd=%h, required %h %h", cyc, a_data, b_rdata,
                         e_ad, e_bd);
            end
        end
        vectors++;
        if (first_ready !== DEPTH) begin
            miscompares++;
            $display("FAIL clear_latency: ready after %0d cycles, required %0d", first_ready, DEPTH);
        end
    endtask

    task automatic test_read_all();
        int cnt = 0;
        apply(1, 0, 0, 0, 0, 0, '0);
        do begin
            apply(0, 0, 0, 0, 0, 0, '0);
            cnt++;
        end while (!ready && cnt < 2 * DEPTH);
        vectors++;
        if (cnt !== DEPTH) begin
            miscompares++;
            $display("FAIL read_all_latency: ready after %0d cycles, required %0d", cnt, DEPTH);
        end
        for (int i = 0; i < DEPTH; i++) begin
            apply(0, 1, i, 1, 0, DEPTH - 1 - i, '0);
            vectors++;
            if (a_valid !== 1'b1 || b_valid !== 1'b1 || a_data !== 16'h0 || b_rdata !== 16'h0) begin
                miscompares++;
                $display("FAIL read_all addr %0d: av=%b bv=%b ad=%h bd=%h, required 1 1 0000 0000", i,
                         a_valid, b_valid, a_data, b_rdata);
            end
        end
    endtask

    task automatic test_directed();
        apply(0, 0, 0, 1, 1, 0, 16'h0008);
        vectors++;
        if (b_valid !== 1'b0 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL write_no_valid: bv=%b err=%b, required 0 0", b_valid, err);
        end
        apply(0, 1, 0, 0, 0, 0, '0);
        vectors++;
        if (a_valid !== 1'b1 || a_data !== 16'h0008) begin
            miscompares++;
            $display("FAIL read_addr0: av=%b ad=%h, required 1 0008", a_valid, a_data);
        end
        apply(0, 0, 0, 0, 0, 0, '0);
        vectors++;
        if (a_valid !== 1'b0 || a_data !== 16'h0008) begin
            miscompares++;
            $display("FAIL read_hold: av=%b ad=%h, required 0 0008", a_valid, a_data);
        end
        apply(0, 0, 0, 1, 1, 5, 16'h00AA);
        apply(0, 1, 5, 1, 1, 5, 16'h1234);
        vectors++;
        if (a_valid !== 1'b1 || a_data !== 16'h00AA) begin
            miscompares++;
            $display("FAIL rbw_old: av=%b ad=%h, required 1 00aa", a_valid, a_data);
        end
        apply(0, 0, 0, 1, 0, 5, '0);
        vectors++;
        if (b_valid !== 1'b1 || b_rdata !== 16'h1234) begin
            miscompares++;
            $display("FAIL b_read_new: bv=%b bd=%h, required 1 1234", b_valid, b_rdata);
        end
        apply(0, 1, 5, 0, 0, 0, '0);
        vectors++;
        if (a_valid !== 1'b1 || a_data !== 16'h1234) begin
            miscompares++;
            $display("FAIL a_read_new: av=%b ad=%h, required 1 1234", a_valid, a_data);
        end
        apply(0, 0, 0, 1, 1, 300, 16'hBEEF);
        vectors++;
        if (err !== 1'b1 || b_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL oob_write: err=%b bv=%b, required 1 0", err, b_valid);
        end
        apply(0, 1, 300, 0, 0, 0, '0);
        vectors++;
        if (a_valid !== 1'b1 || a_data !== 16'h0 || err !== 1'b1) begin
            miscompares++;
            $display("FAIL oob_read: av=%b ad=%h err=%b, required 1 0000 1", a_valid, a_data, err);
        end
        // 300 must not alias onto 43 (mod DEPTH) or 44 (mod 256).
        apply(0, 1, 43, 1, 0, 44, '0);
        vectors++;
        if (a_data !== 16'h0 || b_rdata !== 16'h0 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL no_alias: ad=%h bd=%h err=%b, required 0000 0000 0", a_data, b_rdata, err);
        end
        apply(0, 1, 400, 1, 1, 300, 16'h7777);
        vectors++;
        if (err !== 1'b1) begin
            miscompares++;
            $display("FAIL both_oob: err=%b, required 1", err);
        end
        apply(0, 0, 0, 1, 1, DEPTH - 1, 16'hC0DE);
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL err_pulse_once: err=%b, required 0", err);
        end
        apply(0, 1, DEPTH - 1, 1, 0, DEPTH, '0);
        vectors++;
        if (a_data !== 16'hC0DE || b_rdata !== 16'h0 || err !== 1'b1 || b_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL last_word: ad=%h bd=%h err=%b bv=%b, required c0de 0000 1 1", a_data,
                     b_rdata, err, b_valid);
        end
    endtask

    task automatic test_mid_clear_reset();
        int cnt = 0;
        apply(0, 0, 0, 1, 1, 7, 16'h5555);
        // Read accepted on this edge, reset raised right after it.
        reset  = 1'b0;
        a_req  = 1'b1;
        a_addr = AW'(7);
        b_req  = 1'b0;
        @(posedge clock);
        reset = 1'b1;
        a_req = 1'b0;
        #1;
        vectors++;
        if (a_valid !== 1'b0 || ready !== 1'b0 || a_data !== 16'h0) begin
            miscompares++;
            $display("FAIL read_before_reset: av=%b rdy=%b ad=%h, required 0 0 0000", a_valid, ready,
                     a_data);
        end
        apply(1, 0, 0, 0, 0, 0, '0);
        for (int i = 0; i < 100; i++) apply(0, 0, 0, 0, 0, 0, '0);
        vectors++;
        if (ready !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_clear_ready: ready=%b, required 0", ready);
        end
        apply(1, 0, 0, 0, 0, 0, '0);
        do begin
            apply(0, 0, 0, 0, 0, 0, '0);
            cnt++;
        end while (!ready && cnt < 2 * DEPTH);
        vectors++;
        if (cnt !== DEPTH) begin
            miscompares++;
            $display("FAIL mid_clear_latency: ready after %0d cycles, required %0d", cnt, DEPTH);
        end
        apply(0, 1, 7, 1, 0, 5, '0);
        vectors++;
        if (a_data !== 16'h0 || b_rdata !== 16'h0 || a_valid !== 1'b1 || b_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL cleared_words: ad=%h bd=%h av=%b bv=%b, required 0000 0000 1 1", a_data,
                     b_rdata, a_valid, b_valid);
        end
    endtask

    task automatic test_random();
        int   aa, ba;
        logic rst;
        for (int n = 0; n < 1500; n++) begin
            rst = ($urandom_range(0, 599) == 0);
            aa  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : $urandom_range(0, DEPTH + 20);
            ba  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : $urandom_range(0, DEPTH + 20);
            apply(rst, 1'($urandom), aa, 1'($urandom), 1'($urandom), ba, DW'($urandom));
            vectors++;
            if (ready !== e_rdy || a_valid !== e_av || b_valid !== e_bv || err !== e_err) begin
                miscompares++;
                $display("FAIL random_ctl %0d: rdy/av/bv/err=%b%b%b%b, required %b%b%b%b", n, ready,
                         a_valid, b_valid, err, e_rdy, e_av, e_bv, e_err);
            end
            vectors++;
            if (a_data !== e_ad || b_rdata !== e_bd) begin
                miscompares++;
                $display("FAIL random_data %0d: ad=%h bd=%h, required %h %h", n, a_data, b_rdata,
                         e_ad, e_bd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clear_ignored();
        test_read_all();
        test_directed();
        test_mid_clear_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
